// File: rtl/idu_seq.sv
// rtl/idu_seq.sv - fetch, decode and execute-phase sequencer for the multicycle NPC core
module idu_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic        inst_ren,
    output logic [31:0] inst_addr,
    input  logic        inst_valid,
    input  logic [31:0] inst_rdata,
    output logic [2:0]  EXU_en,
    output logic [6:0]  tp,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [31:0] imm,
    input  logic        halt,
    input  logic        ebreak,
    output logic        stop,
    output logic        stop_cause,
    output logic [31:0] inst_cnt
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EX0, S_EX1, S_EX2, S_EX3, S_EX4, S_REL, S_STOP
    } state_t;

    localparam logic [6:0] TP_INV    = 7'd0;
    localparam logic [6:0] TP_ADDI   = 7'd1;
    localparam logic [6:0] TP_LW     = 7'd2;
    localparam logic [6:0] TP_SW     = 7'd3;
    localparam logic [6:0] TP_SH     = 7'd4;
    localparam logic [6:0] TP_SB     = 7'd5;
    localparam logic [6:0] TP_EBREAK = 7'd6;

    state_t      state;
    state_t      state_next;
    logic [2:0]  exu_sel;
    logic        accept;
    logic [31:0] ir;
    logic [31:0] cnt_q;
    logic [6:0]  dec_tp;
    logic [31:0] dec_imm;

    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        exu_sel    = 3'b111;
        accept     = 1'b0;
        case (state)
            S_FETCH: begin
                // Valid only counts once our own registered request is on the port.
                if (inst_ren && inst_valid) begin
                    accept     = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: state_next = S_EX0;
            S_EX0: begin exu_sel = 3'd0; state_next = S_EX1; end
            S_EX1: begin exu_sel = 3'd1; state_next = S_EX2; end
            S_EX2: begin exu_sel = 3'd2; state_next = S_EX3; end
            S_EX3: begin exu_sel = 3'd3; state_next = S_EX4; end
            S_EX4: begin
                exu_sel    = 3'd4;
                state_next = (halt || ebreak) ? S_STOP : S_REL;
            end
            S_REL:   state_next = S_FETCH;
            S_STOP:  state_next = S_STOP;
            default: state_next = S_FETCH;
        endcase
    end

    always_comb begin
        dec_tp  = TP_INV;
        dec_imm = 32'd0;
        if (ir == 32'h0010_0073) begin
            dec_tp = TP_EBREAK;
        end else begin
            case (ir[6:0])
                7'b0010011: if (ir[14:12] == 3'b000) begin
                    dec_tp  = TP_ADDI;
                    dec_imm = {{20{ir[31]}}, ir[31:20]};
                end
                7'b0000011: if (ir[14:12] == 3'b010) begin
                    dec_tp  = TP_LW;
                    dec_imm = {{20{ir[31]}}, ir[31:20]};
                end
                7'b0100011: begin
                    case (ir[14:12])
                        3'b010:  dec_tp = TP_SW;
                        3'b001:  dec_tp = TP_SH;
                        3'b000:  dec_tp = TP_SB;
                        default: dec_tp = TP_INV;
                    endcase
                    if (dec_tp != TP_INV) dec_imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
                end
                default: dec_tp = TP_INV;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inst_ren   <= 1'b0;
            inst_addr  <= 32'd0;
            ir         <= 32'd0;
            tp         <= 7'd0;
            rs1        <= 5'd0;
            rs2        <= 5'd0;
            rd         <= 5'd0;
            imm        <= 32'd0;
            stop_cause <= 1'b0;
            cnt_q      <= 32'd0;
        end else begin
            // pc is settled by REL, so the address captured on entry to FETCH is current.
            inst_ren <= (state_next == S_FETCH);
            if (state_next == S_FETCH) inst_addr <= pc;
            if (accept) ir <= inst_rdata;
            if (state == S_DECODE) begin
                tp  <= dec_tp;
                rs1 <= ir[19:15];
                rs2 <= ir[24:20];
                rd  <= ir[11:7];
                imm <= dec_imm;
            end
            if (state == S_EX4) begin
                if (halt || ebreak) stop_cause <= ebreak;
                else                cnt_q      <= cnt_q + 32'd1;
            end
        end
    end

    assign EXU_en   = exu_sel;
    assign stop     = (state == S_STOP);
    assign inst_cnt = cnt_q;

endmodule

// File: doc/idu_seq.md
# idu_seq

Fetch, decode and phase sequencer for the multicycle NPC core. It fetches the word at the current `pc` through a valid-handshaked instruction port and decodes it into `tp/rs1/rs2/rd/imm`. It then steps the downstream execute unit through its five phases (`EXU_en` 0→4) followed by one release cycle, and loops. It sits directly upstream of the execute unit, and stops the core when that unit reports `ebreak` or `halt`.

## Interface
- No parameters.
- `clk` in 1: core clock.
- `rst` in 1: synchronous, active-high reset.
- `pc` in 32: current PC, read from regfile entry 32.
- `inst_ren` out 1: instruction read request.
- `inst_addr` out 32: instruction address.
- `inst_valid` in 1: `inst_rdata` valid this cycle.
- `inst_rdata` in 32: fetched instruction word.
- `EXU_en` out 3: execute phase select.
- `tp` out 7: decoded type.
- `rs1` out 5, `rs2` out 5, `rd` out 5: register indices.
- `imm` out 32: sign-extended immediate.
- `halt` in 1, `ebreak` in 1: execute-unit status.
- `stop` out 1: core stopped.
- `stop_cause` out 1: 1 = ebreak, 0 = halt.
- `inst_cnt` out 32: retired-instruction counter.

## Operation
- States: FETCH, DECODE, EX0, EX1, EX2, EX3, EX4, REL, STOP.
- `EXU_en` per state:
  - FETCH, DECODE, REL, STOP → 3'b111.
  - EXn → n, i.e. EX0=000 … EX4=100.
- FETCH:
  - `inst_ren`=1, `inst_addr`=`pc`.
  - On `inst_valid`=1: latch `inst_rdata` into the instruction register, drop `inst_ren` next cycle, go to DECODE.
  - Otherwise hold FETCH with the request asserted.
- DECODE: register `tp/rs1/rs2/rd/imm` from the latched word, then go to EX0.
  - `rs1`=[19:15], `rs2`=[24:20], `rd`=[11:7], always extracted.
  - opcode 0010011, funct3 000 → `I_ADDI` (7'd1); imm = sext([31:20]).
  - opcode 0000011, funct3 010 → `I_LW` (7'd2); imm = sext([31:20]).
  - opcode 0100011: funct3 010 → `S_SW` (7'd3), 001 → `S_SH` (7'd4), 000 → `S_SB` (7'd5); imm = sext({[31:25],[11:7]}).
  - Word exactly 32'h00100073 → `EBREAK` (7'd6); imm = 0.
  - Anything else → `INV` (7'd0); imm = 0. The execute unit raises `halt` for it.
- EX0 → EX1 → EX2 → EX3 → EX4, one cycle each, unconditional.
- EX4:
  - `halt` or `ebreak` high → STOP; `stop_cause` = `ebreak`.
  - Otherwise → REL, and `inst_cnt` += 1 (wraps 32'hFFFFFFFF → 0).
- REL: one cycle (execute unit releases buses, `pc` update becomes visible), then FETCH.
- STOP is terminal until `rst`.
  - `stop`=1, `EXU_en`=111, `inst_ren`=0.
  - Decode outputs and `inst_cnt` frozen.
- Decode outputs are stable from DECODE exit through EX4 and change only in DECODE.

## Timing
- Reset values:
  - State = FETCH.
  - `EXU_en`=3'b111, `inst_ren`=0, `inst_addr`=0.
  - `tp/rs1/rs2/rd/imm`=0.
  - `stop`=0, `stop_cause`=0, `inst_cnt`=0, instruction register = 0.
- `inst_ren` and `inst_addr` are registered: first request is visible one cycle after `rst` deasserts.
- `inst_valid` is honoured only while `inst_ren`=1; it is ignored in all other states.
- Throughput: latency L = cycles from request to `inst_valid` (L ≥ 1). Instruction period = L + 7 cycles (FETCH L, DECODE 1, EX0–EX4 5, REL 1).
- The `pc` write happens at the EX4 clock edge. `pc` is sampled again no earlier than the first FETCH cycle after REL.
- `halt`/`ebreak` are sampled only in EX4 (they are set by the EX3 edge). Assertions in any other state are ignored.
- `rst` during any state, including STOP or mid-FETCH:
  - Next cycle state = FETCH, outputs at reset values.
  - `EXU_en`=111 forces the execute unit to release.
  - An `inst_valid` arriving in the reset cycle is dropped.
- `halt` and `ebreak` both high in EX4 → STOP, `stop_cause`=1.

## Test plan
- Reset then `pc`=0x80000000, memory returns 0x00500093 (addi x1,x0,5) with L=1 → `inst_addr`=0x80000000; then `tp`=1, `rs1`=0, `rd`=1, `imm`=5; `EXU_en` sequence 111,111,000,001,010,011,100,111; `inst_cnt`=1 eight cycles after the request.
- sw x2,-4(x1) (0xFE20AE23) → `tp`=3, `rs1`=1, `rs2`=2, `imm`=0xFFFFFFFC. sh (funct3 001) → `tp`=4; sb (funct3 000) → `tp`=5.
- `inst_valid` delayed 4 cycles → `inst_ren` held high for all 4 cycles with a stable address; period = 11 cycles.
- 0x00100073 with `ebreak`=1 in EX4 → `stop`=1, `stop_cause`=1, `EXU_en`=111 thereafter, no further fetch, `inst_cnt` unchanged. Word 0xFFFFFFFF with `halt`=1 → `tp`=0, `stop_cause`=0.
- `inst_cnt` preloaded near wrap via 2^32−1 retirements (force) → next retirement gives 0.
- `rst` pulsed in EX2 and again in STOP → next cycle FETCH, `EXU_en`=111, `stop`=0, `inst_cnt`=0, fetch restarts at current `pc`.
